// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, RAM handshake state, and the memory arbiter
// grant state (exported so debug views can decode it).
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single RAM port between instruction fetch and data
// access. Data has priority; one requester is granted at a time, with an IDLE
// cycle between grants.
//
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   iREN, iaddr -> iwait, iload   instruction read request / response
//   dREN, dWEN, daddr, dstore     data request
//   dwait, dload                  data response
//   ramREN, ramWEN, ramaddr,      RAM request (zero when nothing granted)
//   ramstore
//   ramload, ramstate             RAM response
//   merr                          pulse when a granted access ends in ERROR
//
// Build option: define MEM_ARB_FAIR_EN to bound instruction starvation. After
// DSTREAK_MAX consecutive data completions with iREN waiting, the next grant
// goes to the instruction side.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned DSTREAK_MAX = 4
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      merr
);

  arb_state_t state_q, state_d;

  logic dreq;
  logic done;
  logic fair_force;

  assign dreq = dREN | dWEN;
  assign done = (ramstate == ACCESS) || (ramstate == ERROR);

  // Grant state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MEM_ARB_FAIR_EN
  localparam int unsigned STREAK_W = 4;

  logic [STREAK_W-1:0] dstreak_q, dstreak_d;

  // Consecutive data completions seen while an instruction fetch waits
  always_comb begin
    dstreak_d = dstreak_q;
    if ((state_q == DGNT) && dreq && done) begin
      if (!iREN) begin
        dstreak_d = '0;
      end else if (dstreak_q != {STREAK_W{1'b1}}) begin
        dstreak_d = dstreak_q + STREAK_W'(1);
      end
    end else if ((state_q == IGNT) && iREN && done) begin
      dstreak_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dstreak_q <= '0;
    end else begin
      dstreak_q <= dstreak_d;
    end
  end

  assign fair_force = iREN && (dstreak_q == STREAK_W'(DSTREAK_MAX));
`else
  logic [3:0] dstreak_max_unused;

  assign dstreak_max_unused = 4'(DSTREAK_MAX);
  assign fair_force         = 1'b0;
`endif

  // Next-state, RAM request steering and response routing
  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    merr     = 1'b0;
    iwait    = iREN;
    dwait    = dreq;

    unique case (state_q)
      IDLE: begin
        if (fair_force) begin
          state_d = IGNT;
        end else if (dreq) begin
          state_d = DGNT;
        end else if (iREN) begin
          state_d = IGNT;
        end
      end

      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        // A write wins when both enables are raised
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dload    = ramload;
        if (!dreq) begin
          state_d = IDLE;
        end else if (done) begin
          dwait   = 1'b0;
          merr    = (ramstate == ERROR);
          state_d = IDLE;
        end
      end

      IGNT: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        iload   = ramload;
        if (!iREN) begin
          state_d = IDLE;
        end else if (done) begin
          iwait   = 1'b0;
          merr    = (ramstate == ERROR);
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes the expected completion of
// each access; a negedge monitor pops and checks whenever a wait drops.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK;
  logic      RST;
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      merr;

  mem_arbiter #(.DSTREAK_MAX(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .merr     (merr)
  );

  typedef struct packed {
    logic        is_data;
    logic [31:0] load;
    logic        merr;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic is_data, input logic [31:0] load, input logic e_merr);
    exp_t e;
    e.is_data = is_data;
    e.load    = load;
    e.merr    = e_merr;
    exp_q.push_back(e);
  endtask

  // Completion monitor
  logic i_ack, d_ack;
  exp_t got;
  always @(negedge CLK) begin
    i_ack = iREN && !iwait;
    d_ack = (dREN || dWEN) && !dwait;
    if (i_ack || d_ack) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack: got i_ack=%0b d_ack=%0b expected none at %0t",
                 i_ack, d_ack, $time);
      end else begin
        got = exp_q.pop_front();
        chk("ack_kind", 32'(d_ack), 32'(got.is_data));
        chk("ack_load", d_ack ? dload : iload, got.load);
        chk("ack_merr", 32'(merr), 32'(got.merr));
      end
    end else begin
      chk("merr_no_ack", 32'(merr), 32'd0);
    end
  end

  initial begin
    RST      = 1'b1;
    iREN     = 1'b1;
    iaddr    = '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    ramload  = '0;
    ramstate = FREE;

    // Reset with iREN held
    step();
    step();
    @(negedge CLK);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_ramaddr", ramaddr, 32'd0);

    // Instruction read: BUSY, BUSY, ACCESS
    step();
    RST      = 1'b0;
    iaddr    = 32'h40;
    ramstate = BUSY;
    ramload  = 32'h8C010004;
    push(1'b0, 32'h8C010004, 1'b0);
    step();
    @(negedge CLK);
    chk("ird_c1_ramREN", 32'(ramREN), 32'd1);
    chk("ird_c1_ramaddr", ramaddr, 32'h40);
    chk("ird_c1_iwait", 32'(iwait), 32'd1);
    step();
    @(negedge CLK);
    chk("ird_c2_ramREN", 32'(ramREN), 32'd1);
    step();
    ramstate = ACCESS;
    @(negedge CLK);
    chk("ird_c3_iwait", 32'(iwait), 32'd0);
    step();
    iREN     = 1'b0;
    ramstate = FREE;
    step();

    // Simultaneous instruction read and data write: data first
    step();
    iREN     = 1'b1;
    dWEN     = 1'b1;
    daddr    = 32'h100;
    dstore   = 32'hDEADBEEF;
    ramstate = BUSY;
    ramload  = 32'h11111111;
    push(1'b1, 32'h11111111, 1'b0);
    step();
    ramstate = ACCESS;
    @(negedge CLK);
    chk("dw_ramWEN", 32'(ramWEN), 32'd1);
    chk("dw_ramREN", 32'(ramREN), 32'd0);
    chk("dw_ramaddr", ramaddr, 32'h100);
    chk("dw_ramstore", ramstore, 32'hDEADBEEF);
    chk("dw_iwait", 32'(iwait), 32'd1);
    step();
    dWEN     = 1'b0;
    ramstate = BUSY;
    ramload  = 32'h22222222;
    push(1'b0, 32'h22222222, 1'b0);
    @(negedge CLK);
    chk("gap_ramREN", 32'(ramREN), 32'd0);
    chk("gap_ramaddr", ramaddr, 32'd0);
    step();
    ramstate = ACCESS;
    @(negedge CLK);
    chk("after_d_ramREN", 32'(ramREN), 32'd1);
    chk("after_d_ramaddr", ramaddr, 32'h40);
    chk("after_d_ramstore", ramstore, 32'd0);
    step();
    iREN     = 1'b0;
    ramstate = FREE;
    step();

    // dREN and dWEN together: write wins
    step();
    dREN     = 1'b1;
    dWEN     = 1'b1;
    daddr    = 32'h200;
    dstore   = 32'hCAFEF00D;
    ramstate = BUSY;
    push(1'b1, 32'h33333333, 1'b0);
    step();
    ramstate = ACCESS;
    ramload  = 32'h33333333;
    @(negedge CLK);
    chk("both_ramWEN", 32'(ramWEN), 32'd1);
    chk("both_ramREN", 32'(ramREN), 32'd0);
    step();
    dREN     = 1'b0;
    dWEN     = 1'b0;
    ramstate = FREE;
    step();

    // ERROR on a data read, then a clean regrant
    step();
    dREN     = 1'b1;
    dWEN     = 1'b0;
    daddr    = 32'h300;
    ramstate = BUSY;
    push(1'b1, 32'h44444444, 1'b1);
    step();
    ramstate = ERROR;
    ramload  = 32'h44444444;
    step();
    ramstate = BUSY;
    push(1'b1, 32'h55555555, 1'b0);
    step();
    ramstate = ACCESS;
    ramload  = 32'h55555555;
    @(negedge CLK);
    chk("regrant_ramREN", 32'(ramREN), 32'd1);
    step();
    dREN     = 1'b0;
    ramstate = FREE;
    step();

    // Instruction abort mid-grant
    step();
    iREN     = 1'b1;
    iaddr    = 32'h80;
    ramstate = BUSY;
    step();
    @(negedge CLK);
    chk("abort_c1_ramaddr", ramaddr, 32'h80);
    iREN = 1'b0;
    step();
    @(negedge CLK);
    chk("abort_c2_ramREN", 32'(ramREN), 32'd0);
    chk("abort_c2_ramaddr", ramaddr, 32'd0);
    step();

    // Reset in the middle of a data grant
    step();
    dREN  = 1'b1;
    daddr = 32'h700;
    step();
    @(negedge CLK);
    chk("rstmid_c1_ramREN", 32'(ramREN), 32'd1);
    RST = 1'b1;
    step();
    @(negedge CLK);
    chk("rstmid_c2_ramREN", 32'(ramREN), 32'd0);
    chk("rstmid_c2_dwait", 32'(dwait), 32'd1);
    RST  = 1'b0;
    dREN = 1'b0;
    step();
    step();

    // Both sides held with the RAM always ready
    step();
    dREN     = 1'b1;
    iREN     = 1'b1;
    daddr    = 32'h500;
    iaddr    = 32'h600;
    ramstate = ACCESS;
    ramload  = 32'h66666666;
`ifdef MEM_ARB_FAIR_EN
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 5; j++) begin
        push((j < 4) ? 1'b1 : 1'b0, 32'h66666666, 1'b0);
        step();
        @(negedge CLK);
        chk("fair_ramaddr", ramaddr, (j < 4) ? 32'h500 : 32'h600);
        step();
      end
    end
`else
    for (int k = 0; k < 6; k++) begin
      push(1'b1, 32'h66666666, 1'b0);
      step();
      @(negedge CLK);
      chk("strict_iwait_grant", 32'(iwait), 32'd1);
      step();
      @(negedge CLK);
      chk("strict_iwait_idle", 32'(iwait), 32'd1);
    end
`endif
    dREN     = 1'b0;
    iREN     = 1'b0;
    ramstate = FREE;
    step();
    step();
    @(negedge CLK);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter sharing the single RAM port between the instruction-fetch and data-access requesters of the CPU. It sits between the request unit / datapath side (iREN, dREN, dWEN) and the RAM, grants one requester at a time, forwards its address, store data and enables, and returns load data with per-requester wait signals. Default priority is data over instruction; an optional fairness counter bounds instruction starvation.

## Interface
- DSTREAK_MAX, 4: consecutive data grants allowed while an instruction request waits (fairness build only); range 1..15
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction word address
- iwait  out  1  high while instruction request not yet complete
- iload  out  32  instruction read data
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- dwait  out  1  high while data request not yet complete
- dload  out  32  data read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- merr  out  1  one-cycle pulse when the granted access ends with ERROR

## Operation
- Decided interface: one clock; reset is synchronous and active-high. Clock port CLK, reset port RST.
- FSM states: IDLE, IGNT, DGNT (registered).
- IDLE: no RAM enables. Next: DGNT if dREN|dWEN, else IGNT if iREN, else IDLE. Fairness override below.
- DGNT: ramaddr=daddr, ramstore=dstore. dWEN wins if both dWEN and dREN: ramWEN=1, ramREN=0. Otherwise ramREN=dREN.
- IGNT: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
- Completion: granted state with ramstate==ACCESS or ERROR. The granted wait drops combinationally that cycle. dload/iload=ramload that cycle. Next state IDLE.
- ERROR additionally pulses merr for that same cycle.
- BUSY/FREE in a grant state: hold state and outputs.
- Abort: if the granted requester drops its request before completion, return to IDLE next cycle. No ack, no merr.
- iwait=iREN & ~(IGNT & done). dwait=(dREN|dWEN) & ~(DGNT & done).
- iload/dload = ramload when their grant is active, else 0.
- Ungranted RAM outputs are 0.

## Timing
- Reset (cycle after RST sampled high): state IDLE, streak counter 0. All outputs 0 except iwait/dwait, which follow the requests combinationally.
- RST mid-grant: access abandoned and enables low the next cycle; no ack.
- Minimum latency: request sampled in IDLE at cycle 0, grant at cycle 1, wait low at cycle 1 if RAM returns ACCESS immediately.
- At least one IDLE cycle separates consecutive grants. A requester holding its request after ack is regranted.
- Requesters must hold address and data stable while their wait is high.

## Configuration
- MEM_ARB_FAIR_EN defined:
  - 4-bit dstreak counter increments on each data completion while iREN is high.
  - It clears on an instruction completion, or on a data completion with iREN low.
  - In IDLE with dstreak==DSTREAK_MAX and iREN high, go to IGNT even if data is requesting.
- MEM_ARB_FAIR_EN undefined: strict data priority, no counter; DSTREAK_MAX is ignored.

## Structure
- Shared package cpu_types_pkg already holds word_t and ramstate_t. Add arb_state_t {IDLE, IGNT, DGNT} there for debug visibility.
- No sub-module; the streak counter is inline under the macro.

## Test plan
- Reset: assert RST with iREN=1 -> next cycle ramREN=0, ramWEN=0, state IDLE, iwait=1.
- Instruction read: iREN, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS with ramload=0x8C010004 -> ramREN=1 and ramaddr=0x40 from cycle 1; iwait low and iload=0x8C010004 at cycle 3.
- Simultaneous iREN and dWEN, daddr=0x100, dstore=0xDEADBEEF -> DGNT first with ramWEN=1; after ack, IDLE, then IGNT.
- Both dREN and dWEN high -> ramWEN=1, ramREN=0.
- ERROR on data read -> dwait low and merr pulse for one cycle; no merr on the following grant.
- Fairness (MEM_ARB_FAIR_EN, DSTREAK_MAX=4), dREN and iREN held high -> exactly 4 data grants, then one instruction grant, repeating. Without the macro, iwait never drops.
